// File: rtl/branch_resolver_pkg.sv
// ============================================================================
// branch_resolver_pkg : shared encodings, FSM state codes and helpers for the
//                       branch resolver slice.
// Revision: 1.0
// ============================================================================
`default_nettype none

package branch_resolver_pkg;

  localparam logic TAKEN     = 1'b1;
  localparam logic NOT_TAKEN = 1'b0;

  localparam int PC_INCR = 4;

  typedef enum logic {
    BR_IDLE  = 1'b0,
    BR_FLUSH = 1'b1
  } br_state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/branch_resolver_if.sv
// ============================================================================
// branch_resolver_if : fetch/execute inputs and table-update/redirect outputs
//                      of the branch resolver.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface branch_resolver_if #(
  parameter int PC_W  = 32,
  parameter int IDX_W = 8
);

  logic              fetch_push;
  logic [PC_W-1:0]   fetch_pc;
  logic              fetch_pred_taken;
  logic [PC_W-1:0]   fetch_pred_target;
  logic              queue_full;

  logic              ex_valid;
  logic              ex_taken;
  logic [PC_W-1:0]   ex_target;

  logic              redirect_valid;
  logic [PC_W-1:0]   redirect_pc;
  logic              flush;

  logic              upd_we;
  logic [IDX_W-1:0]  upd_addr;
  logic [PC_W:0]     upd_data;

  logic [15:0]       resolved_count;
  logic [15:0]       mispredict_count;

  modport master (
    output fetch_push, fetch_pc, fetch_pred_taken, fetch_pred_target,
    output ex_valid, ex_taken, ex_target,
    input  queue_full, redirect_valid, redirect_pc, flush,
    input  upd_we, upd_addr, upd_data, resolved_count, mispredict_count
  );

  modport slave (
    input  fetch_push, fetch_pc, fetch_pred_taken, fetch_pred_target,
    input  ex_valid, ex_taken, ex_target,
    output queue_full, redirect_valid, redirect_pc, flush,
    output upd_we, upd_addr, upd_data, resolved_count, mispredict_count
  );

endinterface

`default_nettype wire

// File: rtl/branch_resolver_queue.sv
// ============================================================================
// branch_queue : synchronous FIFO of in-flight predictions with clear.
// Revision: 1.0
// ============================================================================
`default_nettype none

module branch_queue #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 65,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count,
  output logic             full
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && (count != '0);
  assign head    = mem[rd_ptr];

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) begin
      mem[wr_ptr] <= din;
    end
  end

endmodule

`default_nettype wire

// File: rtl/branch_resolver.sv
// ============================================================================
// branch_resolver : retires fetch predictions against execute outcomes,
//                   trains the prediction table and redirects on mispredict.
// Revision: 1.0
// ============================================================================
`default_nettype none

module branch_resolver
  import branch_resolver_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int FLUSH_CYCLES = 2,
  parameter int IDX_W        = 8,
  parameter int PC_W         = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  branch_resolver_if.slave     bus
);

  localparam int ENTRY_W = 2 * PC_W + 1;
  localparam int CNT_W   = $clog2(DEPTH) + 1;
  localparam int FC_W    = $clog2(FLUSH_CYCLES) + 1;

  br_state_e        state;
  br_state_e        state_next;
  logic [FC_W-1:0]  flush_cnt;
  logic [FC_W-1:0]  flush_cnt_next;

  logic [ENTRY_W-1:0] q_head;
  logic [CNT_W-1:0]   q_count;
  logic               q_full;
  logic [PC_W-1:0]    head_pc;
  logic               head_taken;
  logic [PC_W-1:0]    head_target;

  logic               resolve;
  logic               mispredict;
  logic               push_ok;
  logic [PC_W-1:0]    correct_pc;

  logic               upd_we_r;
  logic [IDX_W-1:0]   upd_addr_r;
  logic [PC_W:0]      upd_data_r;
  logic               redirect_valid_r;
  logic [PC_W-1:0]    redirect_pc_r;
  logic [15:0]        resolved_count_r;
  logic [15:0]        mispredict_count_r;

  assign {head_pc, head_taken, head_target} = q_head;

  assign resolve    = (state == BR_IDLE) && bus.ex_valid && (q_count != '0);
  // A not-taken branch has no meaningful target, so only direction matters.
  assign mispredict = resolve &&
                      ((head_taken != bus.ex_taken) ||
                       ((bus.ex_taken == TAKEN) && (head_target != bus.ex_target)));
  assign push_ok    = bus.fetch_push && !q_full && (state == BR_IDLE) && !mispredict;
  assign correct_pc = (bus.ex_taken == NOT_TAKEN) ? head_pc + PC_W'(PC_INCR)
                                                  : bus.ex_target;

  branch_queue #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_queue (
    .clk   (clk),
    .reset (reset),
    .push  (push_ok),
    .pop   (resolve),
    .clear (mispredict),
    .din   ({bus.fetch_pc, bus.fetch_pred_taken, bus.fetch_pred_target}),
    .head  (q_head),
    .count (q_count),
    .full  (q_full)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= BR_IDLE;
      flush_cnt <= '0;
    end else begin
      state     <= state_next;
      flush_cnt <= flush_cnt_next;
    end
  end

  // The redirect cycle is the first flush cycle, so the counter starts one short.
  always_comb begin
    state_next     = state;
    flush_cnt_next = flush_cnt;
    case (state)
      BR_IDLE: begin
        if (mispredict) begin
          state_next     = BR_FLUSH;
          flush_cnt_next = FC_W'(FLUSH_CYCLES - 1);
        end
      end
      BR_FLUSH: begin
        if (flush_cnt == '0) begin
          state_next = BR_IDLE;
        end else begin
          flush_cnt_next = flush_cnt - 1'b1;
        end
      end
      default: begin
        state_next     = BR_IDLE;
        flush_cnt_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      upd_we_r           <= 1'b0;
      upd_addr_r         <= '0;
      upd_data_r         <= '0;
      redirect_valid_r   <= 1'b0;
      redirect_pc_r      <= '0;
      resolved_count_r   <= '0;
      mispredict_count_r <= '0;
    end else begin
      upd_we_r         <= resolve;
      redirect_valid_r <= mispredict;
      if (resolve) begin
        upd_addr_r       <= head_pc[IDX_W+1:2];
        upd_data_r       <= {bus.ex_target, bus.ex_taken};
        resolved_count_r <= sat_inc16(resolved_count_r);
      end
      if (mispredict) begin
        redirect_pc_r      <= correct_pc;
        mispredict_count_r <= sat_inc16(mispredict_count_r);
      end
    end
  end

  assign bus.queue_full       = q_full;
  assign bus.flush            = (state == BR_FLUSH);
  assign bus.upd_we           = upd_we_r;
  assign bus.upd_addr         = upd_addr_r;
  assign bus.upd_data         = upd_data_r;
  assign bus.redirect_valid   = redirect_valid_r;
  assign bus.redirect_pc      = redirect_pc_r;
  assign bus.resolved_count   = resolved_count_r;
  assign bus.mispredict_count = mispredict_count_r;

endmodule

`default_nettype wire

// File: tb/tb_branch_resolver.sv
// ============================================================================
// tb_branch_resolver : vector table, directed corner sequences and a random
//                      run against a queue-based reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_branch_resolver;

  localparam int DEPTH        = 4;
  localparam int FLUSH_CYCLES = 2;
  localparam int IDX_W        = 8;
  localparam int PC_W         = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  branch_resolver_if #(.PC_W(PC_W), .IDX_W(IDX_W)) bus ();

  branch_resolver #(
    .DEPTH        (DEPTH),
    .FLUSH_CYCLES (FLUSH_CYCLES),
    .IDX_W        (IDX_W),
    .PC_W         (PC_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] pc;
    logic        pt;
    logic [31:0] ptgt;
    logic        et;
    logic [31:0] etgt;
    logic        mp;
    logic [31:0] rpc;
    logic [7:0]  addr;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic        pt;
    logic [31:0] tgt;
  } ent_t;

  vec_t        vecs [7];
  ent_t        m_q [$];
  int          m_flush_rem;
  int          m_res;
  int          m_mis;
  logic [7:0]  wrap_addr [6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.fetch_push        = 1'b0;
    bus.fetch_pc          = '0;
    bus.fetch_pred_taken  = 1'b0;
    bus.fetch_pred_target = '0;
    bus.ex_valid          = 1'b0;
    bus.ex_taken          = 1'b0;
    bus.ex_target         = '0;
  endtask

  task automatic do_reset();
    idle_in();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic set_push(input logic [31:0] pc, input logic pt, input logic [31:0] tgt);
    bus.fetch_push        = 1'b1;
    bus.fetch_pc          = pc;
    bus.fetch_pred_taken  = pt;
    bus.fetch_pred_target = tgt;
  endtask

  task automatic push1(input logic [31:0] pc, input logic pt, input logic [31:0] tgt);
    set_push(pc, pt, tgt);
    tick();
    bus.fetch_push = 1'b0;
  endtask

  task automatic set_ex(input logic et, input logic [31:0] etgt);
    bus.ex_valid  = 1'b1;
    bus.ex_taken  = et;
    bus.ex_target = etgt;
  endtask

  task automatic resolve1(input logic et, input logic [31:0] etgt);
    set_ex(et, etgt);
    tick();
    bus.ex_valid = 1'b0;
  endtask

  initial begin
    ent_t        h;
    logic        idle, res, mp, pok;
    int          sz;
    logic [7:0]  e_addr;
    logic [32:0] e_data;
    logic [31:0] e_rpc;

    //            pc            pt    ptgt          et    etgt          mp    rpc           addr
    vecs[0] = '{32'h0000_0100, 1'b0, 32'h0,        1'b0, 32'h0000_0200, 1'b0, 32'h0,        8'h40};
    vecs[1] = '{32'h0000_0104, 1'b0, 32'h0,        1'b1, 32'h0000_0300, 1'b1, 32'h0000_0300, 8'h41};
    vecs[2] = '{32'h0000_0108, 1'b1, 32'h0000_0400, 1'b1, 32'h0000_0480, 1'b1, 32'h0000_0480, 8'h42};
    vecs[3] = '{32'hFFFF_FFFC, 1'b1, 32'h0000_0010, 1'b0, 32'h0000_0020, 1'b1, 32'h0000_0000, 8'hFF};
    vecs[4] = '{32'h0000_2010, 1'b1, 32'h0000_2400, 1'b1, 32'h0000_2400, 1'b0, 32'h0,        8'h04};
    vecs[5] = '{32'h0000_03F8, 1'b1, 32'h0000_0500, 1'b0, 32'h0000_0600, 1'b1, 32'h0000_03FC, 8'hFE};
    vecs[6] = '{32'h0000_0120, 1'b0, 32'h0000_0999, 1'b0, 32'h0000_0777, 1'b0, 32'h0,        8'h48};

    wrap_addr[0] = 8'h00; wrap_addr[1] = 8'h01; wrap_addr[2] = 8'h02;
    wrap_addr[3] = 8'h03; wrap_addr[4] = 8'h06; wrap_addr[5] = 8'h07;

    // Reset state.
    do_reset();
    chk("rst_full",    bus.queue_full, 0);
    chk("rst_flush",   bus.flush, 0);
    chk("rst_upd_we",  bus.upd_we, 0);
    chk("rst_redir",   bus.redirect_valid, 0);
    chk("rst_res_cnt", bus.resolved_count, 0);
    chk("rst_mis_cnt", bus.mispredict_count, 0);

    // Single-branch vector table.
    foreach (vecs[i]) begin
      do_reset();
      push1(vecs[i].pc, vecs[i].pt, vecs[i].ptgt);
      resolve1(vecs[i].et, vecs[i].etgt);
      chk($sformatf("vec%0d_upd_we", i),  bus.upd_we, 1);
      chk($sformatf("vec%0d_addr", i),    bus.upd_addr, vecs[i].addr);
      chk($sformatf("vec%0d_data", i),    bus.upd_data, {vecs[i].etgt, vecs[i].et});
      chk($sformatf("vec%0d_redir", i),   bus.redirect_valid, vecs[i].mp);
      chk($sformatf("vec%0d_flush", i),   bus.flush, vecs[i].mp);
      chk($sformatf("vec%0d_res", i),     bus.resolved_count, 1);
      chk($sformatf("vec%0d_mis", i),     bus.mispredict_count, vecs[i].mp);
      if (vecs[i].mp)
        chk($sformatf("vec%0d_rpc", i), bus.redirect_pc, vecs[i].rpc);
      tick();
      chk($sformatf("vec%0d_we_pulse", i), bus.upd_we, 0);
    end

    // Direction mispredict with two younger entries; flush lasts FLUSH_CYCLES.
    do_reset();
    push1(32'h104, 1'b0, 32'h0);
    push1(32'h108, 1'b1, 32'h50);
    push1(32'h10C, 1'b0, 32'h0);
    resolve1(1'b1, 32'h300);
    chk("dir_redir", bus.redirect_valid, 1);
    chk("dir_rpc",   bus.redirect_pc, 32'h300);
    chk("dir_data",  bus.upd_data, {32'h300, 1'b1});
    chk("dir_flush1", bus.flush, 1);
    tick();
    chk("dir_flush2", bus.flush, 1);
    chk("dir_redir_pulse", bus.redirect_valid, 0);
    tick();
    chk("dir_flush_end", bus.flush, 0);
    resolve1(1'b0, 32'h0);
    chk("dir_q_empty", bus.upd_we, 0);
    chk("dir_mis_cnt", bus.mispredict_count, 1);
    chk("dir_res_cnt", bus.resolved_count, 1);

    // Target mispredict; pushes during flush are dropped.
    do_reset();
    push1(32'h108, 1'b1, 32'h400);
    resolve1(1'b1, 32'h480);
    chk("tgt_rpc", bus.redirect_pc, 32'h480);
    set_push(32'h500, 1'b0, 32'h0);
    tick();
    chk("tgt_flush2", bus.flush, 1);
    tick();
    bus.fetch_push = 1'b0;
    chk("tgt_flush_end", bus.flush, 0);
    resolve1(1'b0, 32'h0);
    chk("tgt_drop_we", bus.upd_we, 0);
    chk("tgt_res_cnt", bus.resolved_count, 1);

    // Full, rejected pushes and pointer wrap over six resolves.
    do_reset();
    for (int k = 0; k < 4; k++) push1(32'h1000 + 32'(4 * k), 1'b0, 32'h0);
    chk("full_set", bus.queue_full, 1);
    push1(32'h1010, 1'b0, 32'h0);
    chk("full_drop", bus.queue_full, 1);
    set_push(32'h1014, 1'b0, 32'h0);
    resolve1(1'b0, 32'h0);
    bus.fetch_push = 1'b0;
    chk("wrap_we0",   bus.upd_we, 1);
    chk("wrap_addr0", bus.upd_addr, wrap_addr[0]);
    chk("full_pp_rejected", bus.queue_full, 0);
    push1(32'h1018, 1'b0, 32'h0);
    chk("full_again", bus.queue_full, 1);
    for (int k = 1; k < 6; k++) begin
      if (k == 2) set_push(32'h101C, 1'b0, 32'h0);
      resolve1(1'b0, 32'h0);
      bus.fetch_push = 1'b0;
      chk($sformatf("wrap_we%0d", k),   bus.upd_we, 1);
      chk($sformatf("wrap_addr%0d", k), bus.upd_addr, wrap_addr[k]);
    end
    resolve1(1'b0, 32'h0);
    chk("wrap_empty_we", bus.upd_we, 0);
    chk("wrap_res_cnt",  bus.resolved_count, 6);

    // Reset in the first flush cycle.
    do_reset();
    push1(32'h104, 1'b0, 32'h0);
    push1(32'h108, 1'b0, 32'h0);
    resolve1(1'b1, 32'h300);
    chk("rmf_flush1", bus.flush, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rmf_flush", bus.flush, 0);
    chk("rmf_res",   bus.resolved_count, 0);
    chk("rmf_mis",   bus.mispredict_count, 0);
    chk("rmf_full",  bus.queue_full, 0);
    chk("rmf_redir", bus.redirect_valid, 0);
    resolve1(1'b0, 32'h0);
    chk("rmf_q_empty", bus.upd_we, 0);

    // Randomized run against the reference model.
    do_reset();
    m_q.delete();
    m_flush_rem = 0;
    m_res = 0;
    m_mis = 0;
    for (int c = 0; c < 1500; c++) begin
      bus.fetch_push        = ($urandom_range(0, 9) < 6);
      bus.fetch_pc          = $urandom;
      bus.fetch_pred_taken  = 1'($urandom_range(0, 1));
      bus.fetch_pred_target = 32'h1000 + 32'($urandom_range(0, 3) * 4);
      bus.ex_valid          = ($urandom_range(0, 9) < 5);
      if (m_q.size() > 0 && $urandom_range(0, 3) != 0) begin
        bus.ex_taken  = m_q[0].pt;
        bus.ex_target = m_q[0].tgt;
      end else begin
        bus.ex_taken  = 1'($urandom_range(0, 1));
        bus.ex_target = 32'h1000 + 32'($urandom_range(0, 3) * 4);
      end

      sz   = m_q.size();
      idle = (m_flush_rem == 0);
      res  = idle && bus.ex_valid && (sz > 0);
      mp   = 1'b0;
      e_addr = '0; e_data = '0; e_rpc = '0;
      if (res) begin
        h = m_q.pop_front();
        mp = (h.pt != bus.ex_taken) || (bus.ex_taken && (h.tgt != bus.ex_target));
        e_addr = 8'((h.pc / 4) % 256);
        e_data = {bus.ex_target, bus.ex_taken};
        e_rpc  = bus.ex_taken ? bus.ex_target : h.pc + 32'd4;
        if (m_res < 65535) m_res++;
        if (mp && m_mis < 65535) m_mis++;
      end
      pok = bus.fetch_push && (sz < DEPTH) && idle && !mp;
      if (mp) m_q.delete();
      if (pok) m_q.push_back('{bus.fetch_pc, bus.fetch_pred_taken, bus.fetch_pred_target});
      if (m_flush_rem > 0) m_flush_rem--;
      if (mp) m_flush_rem = FLUSH_CYCLES;

      tick();
      chk("rnd_full",  bus.queue_full, (m_q.size() == DEPTH));
      chk("rnd_flush", bus.flush, (m_flush_rem > 0));
      chk("rnd_we",    bus.upd_we, res);
      chk("rnd_redir", bus.redirect_valid, mp);
      chk("rnd_res",   bus.resolved_count, 64'(m_res));
      chk("rnd_mis",   bus.mispredict_count, 64'(m_mis));
      if (res) begin
        chk("rnd_addr", bus.upd_addr, e_addr);
        chk("rnd_data", bus.upd_data, e_data);
      end
      if (mp) chk("rnd_rpc", bus.redirect_pc, e_rpc);
    end

    // Resolved-count saturation: one resolve per cycle via back-to-back push+pop.
    do_reset();
    set_push(32'h40, 1'b0, 32'h0);
    tick();
    set_ex(1'b0, 32'h0);
    for (int k = 0; k < 65535; k++) tick();
    chk("sat_reach", bus.resolved_count, 16'hFFFF);
    tick();
    tick();
    idle_in();
    chk("sat_hold", bus.resolved_count, 16'hFFFF);
    chk("sat_mis",  bus.mispredict_count, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/branch_resolver.md
Name: branch_resolver

Overview:
- Write-side partner of the branch prediction table.
- Holds the predictions issued at fetch in program order and retires each one against the branch outcome from execute.
- Every resolved branch drives one training write (index, target, taken) into the prediction table.
- On a mispredict it raises a redirect plus a timed flush, and discards all younger in-flight predictions.

Parameters:
- DEPTH, 4, in-flight prediction queue entries (power of two, ≥2)
- FLUSH_CYCLES, 2, cycles flush stays high after a mispredict (≥1)
- IDX_W, 8, prediction table index width
- PC_W, 32, PC/target width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- fetch_push  in  1  fetch issued a predicted branch this cycle
- fetch_pc  in  PC_W  PC of that branch
- fetch_pred_taken  in  1  predicted direction (1 = taken)
- fetch_pred_target  in  PC_W  predicted target
- queue_full  out  1  fetch must stall branch issue
- ex_valid  in  1  execute resolved the oldest in-flight branch
- ex_taken  in  1  actual direction
- ex_target  in  PC_W  actual computed target
- redirect_valid  out  1  one-cycle pulse: refetch from redirect_pc
- redirect_pc  out  PC_W  correct next PC
- flush  out  1  squash younger pipeline stages
- upd_we  out  1  write enable to prediction table
- upd_addr  out  IDX_W  table index = pc[IDX_W+1:2]
- upd_data  out  PC_W+1  {ex_target, ex_taken}
- resolved_count  out  16  saturating count of resolved branches
- mispredict_count  out  16  saturating count of mispredicts

Behaviour:
- Reset: reset, synchronous, active-high; clock clk. Clears queue (count 0), FSM to IDLE, and every output and counter to 0.
- Queue:
  - FIFO of {pc, pred_taken, pred_target}.
  - queue_full = (count == DEPTH), from registered count.
  - Push accepted only when fetch_push && !queue_full && state == IDLE && no mispredict this cycle; otherwise the entry is dropped silently.
  - Push and pop in the same cycle: count unchanged. Pointers wrap modulo DEPTH.
- Resolve (state IDLE, ex_valid, count > 0): pop the head entry.
  - mispredict = (pred_taken != ex_taken) || (ex_taken && pred_target != ex_target).
- ex_valid with an empty queue, or in FLUSH: ignored. No update, no counter change.
- Outputs are registered, with latency 1 cycle from the resolving ex_valid edge:
  - upd_we = 1 for exactly one cycle, upd_addr = head.pc[IDX_W+1:2], upd_data = {ex_target, ex_taken}.
  - Every resolved branch trains the table, correct or not.
  - resolved_count increments, saturating at 16'hFFFF.
- Mispredict, in the same registered cycle as upd_we:
  - redirect_valid = 1 (one cycle); redirect_pc = ex_taken ? ex_target : head.pc + 4, wrapping mod 2^PC_W.
  - mispredict_count increments, saturating.
  - Queue cleared: all younger entries are wrong-path.
  - FSM IDLE -> FLUSH.
- FSM:
  - IDLE: flush = 0.
  - FLUSH: flush = 1 for exactly FLUSH_CYCLES cycles, starting with the redirect cycle; a down-counter is loaded with FLUSH_CYCLES-1; then FLUSH -> IDLE.
  - In FLUSH, pushes and ex_valid are ignored.
- Reset mid-FLUSH: immediate IDLE, flush = 0 next cycle, queue empty.
- upd_addr, upd_data and redirect_pc hold their last value when their strobe is low; verification checks them only when the strobe is high.

Decomposition:
- Shared include/package (alongside the existing opcode defines):
  - TAKEN/NOT_TAKEN encodings (reuse existing).
  - FSM state codes: BR_IDLE = 1'b0, BR_FLUSH = 1'b1.
  - PC_INCR = 4.
- One natural sub-module, branch_queue: a parameterised synchronous FIFO with push, pop, clear, head data, count and full. The resolver owns compare, update, redirect, counters and FSM.
- Target size: about 250 RTL lines.

Test Plan:
- Correct not-taken: push pc=0x100, pred_taken=0, then ex_valid ex_taken=0 ex_target=0x200 -> next cycle upd_we=1, upd_addr=0x40, upd_data={0x200,0}; redirect_valid=0, flush=0, resolved_count=1, mispredict_count=0.
- Direction mispredict: push pc=0x104 pred_taken=0, plus 2 younger pushes; ex_valid ex_taken=1 ex_target=0x300 -> redirect_valid=1 with redirect_pc=0x300, flush high for exactly 2 cycles, queue count=0, mispredict_count=1, upd_data={0x300,1}.
- Target mispredict: pred_taken=1 pred_target=0x400, actual taken to 0x480 -> redirect_pc=0x480. A push during the flush cycles is dropped: the next ex_valid is ignored and upd_we stays 0.
- Full/wrap: push 4 entries -> queue_full=1 and a 5th push is dropped. Same-cycle push+pop at full is rejected; a push after the pop succeeds. Resolve 6 branches over wrap-around with all upd_addr values in program order.
- Not-taken mispredict wrap: pc=0xFFFFFFFC, pred_taken=1, actual not taken -> redirect_pc=0x00000000.
- Reset mid-flush plus saturation: assert reset in flush cycle 1 -> flush=0, queue empty, counters 0 next cycle. Preload via 65536 resolves -> resolved_count holds at 16'hFFFF.
